// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants and types for the UART transmit arbiter.
//               Holds the UART register map (TX/RX/DIV) and the arbiter FSM
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // UART register addresses on the Wishbone-style bus
    localparam logic [1:0] c_ADDR_TX  = 2'd0;
    localparam logic [1:0] c_ADDR_RX  = 2'd1;
    localparam logic [1:0] c_ADDR_DIV = 2'd2;

    typedef logic [1:0] wb_addr_t;

    // Arbiter FSM encoding (explicit 3-bit width)
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARB     = 3'd1,
        ST_STROBE  = 3'd2,
        ST_RELEASE = 3'd3,
        ST_GAP     = 3'd4
    } arb_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter_if
// Description : Bus between the arbiter (master) and the UART (slave).
//   wb_addr     - register address (0 = TX, 2 = divider)
//   wb_data_out - write data towards the UART
//   wb_we       - access direction (0 = write for this UART)
//   wb_stb      - bus strobe
//   wb_clk      - bus phase level (1 = strobe phase, 0 = release phase)
//   wb_ack      - acknowledge from the UART
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if;
    import uart_pkg::*;

    wb_addr_t   wb_addr;
    logic [7:0] wb_data_out;
    logic       wb_we;
    logic       wb_stb;
    logic       wb_clk;
    logic       wb_ack;

    modport master (
        output wb_addr, wb_data_out, wb_we, wb_stb, wb_clk,
        input  wb_ack
    );

    modport slave (
        input  wb_addr, wb_data_out, wb_we, wb_stb, wb_clk,
        output wb_ack
    );

endinterface : uart_tx_arbiter_if
`default_nettype wire

// File: rtl/rr_select.sv
`default_nettype none
// ============================================================================
// Module      : rr_select
// Description : One-hot grant selection over a request vector.
//               Default: round-robin, search starts at (ptr + 1) mod N_REQ.
//               With UART_ARB_FIXED_PRIO_EN defined: fixed priority, lowest
//               index wins and ptr is ignored.
//   req   - request vector
//   ptr   - index of the last granted requester
//   grant - one-hot grant (all zero when no request)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_select #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [2:0]       ptr,
    output logic [N_REQ-1:0] grant
);

    localparam int c_IW = $clog2(N_REQ);

    logic [c_IW-1:0] w_idx;

    always_comb begin
        grant = '0;
        w_idx = '0;
`ifdef UART_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N_REQ; i++) begin
            if (req[i] && (grant == '0)) begin
                grant[i] = 1'b1;
            end
        end
`else
        // Walk N_REQ positions starting just after the last grant; the first
        // active request met wins, so the last winner is checked last.
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = c_IW'((int'(ptr) + k) % N_REQ);
            if (req[w_idx] && (grant == '0)) begin
                grant[w_idx] = 1'b1;
            end
        end
`endif
    end

endmodule : rr_select
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Arbitrates N_REQ byte requesters and a baud-divider update
//               onto a single UART register bus. Divider updates always win;
//               bytes are granted round-robin (or fixed priority when the
//               macro UART_ARB_FIXED_PRIO_EN is defined).
//   clk, reset        - clock, synchronous active-high reset
//   req_valid/data    - per-requester byte pending / byte [8i+7:8i]
//   req_ready         - one-cycle accept pulse per requester
//   cfg_div_valid/div - divider update request / value
//   cfg_div_done      - one-cycle pulse when the divider write is acked
//   wb                - UART bus (master modport)
//   grant_id          - index of the current or last granted requester
//   err_timeout       - sticky acknowledge-timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    input  logic               cfg_div_valid,
    input  logic [7:0]         cfg_div,
    output logic               cfg_div_done,
    uart_tx_arbiter_if.master  wb,
    output logic [2:0]         grant_id,
    output logic               err_timeout
);

    // Last count value of a phase before it is declared timed out
    localparam logic [7:0] c_TO_LAST   = 8'(ACK_TIMEOUT - 1);
    localparam logic [2:0] c_GRANT_RST = 3'(N_REQ - 1);

    arb_state_t       r_state;
    arb_state_t       w_next;
    logic [7:0]       r_cnt;
    logic [1:0]       r_addr;
    logic [7:0]       r_data;
    logic             r_is_cfg;
    logic [2:0]       r_grant_id;
    logic             r_err;

    logic [N_REQ-1:0] w_grant;
    logic [2:0]       w_grant_idx;
    logic [7:0]       w_sel_byte;
    logic             w_cfg_pick;
    logic             w_byte_pick;
    logic             w_timeout;
    logic             w_timed_out;

    rr_select #(
        .N_REQ (N_REQ)
    ) u_rr_select (
        .req   (req_valid),
        .ptr   (r_grant_id),
        .grant (w_grant)
    );

    // One-hot grant to index and selected byte
    always_comb begin
        w_grant_idx = '0;
        w_sel_byte  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_grant_idx = 3'(i);
                w_sel_byte  = req_data[8*i +: 8];
            end
        end
    end

    assign w_timed_out = (r_cnt == c_TO_LAST);

    always_comb begin
        w_next      = r_state;
        w_cfg_pick  = 1'b0;
        w_byte_pick = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if ((|req_valid) || cfg_div_valid) begin
                    w_next = ST_ARB;
                end
            end
            ST_ARB: begin
                if (cfg_div_valid) begin
                    w_cfg_pick = 1'b1;
                    w_next     = ST_STROBE;
                end else if (|req_valid) begin
                    w_byte_pick = 1'b1;
                    w_next      = ST_STROBE;
                end else begin
                    // Requests withdrawn: no bus cycle, pointer untouched
                    w_next = ST_IDLE;
                end
            end
            ST_STROBE: begin
                if (wb.wb_ack) begin
                    w_next = ST_RELEASE;
                end else if (w_timed_out) begin
                    w_timeout = 1'b1;
                    w_next    = ST_GAP;
                end
            end
            ST_RELEASE: begin
                if (!wb.wb_ack) begin
                    w_next = ST_GAP;
                end else if (w_timed_out) begin
                    w_timeout = 1'b1;
                    w_next    = ST_GAP;
                end
            end
            ST_GAP:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_addr     <= c_ADDR_TX;
            r_data     <= '0;
            r_is_cfg   <= 1'b0;
            r_grant_id <= c_GRANT_RST;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            // Counter restarts on every phase change so each ack phase
            // gets its own full budget.
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if ((r_state == ST_STROBE) || (r_state == ST_RELEASE)) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_cfg_pick) begin
                r_addr   <= c_ADDR_DIV;
                r_data   <= cfg_div;
                r_is_cfg <= 1'b1;
            end
            if (w_byte_pick) begin
                r_addr     <= c_ADDR_TX;
                r_data     <= w_sel_byte;
                r_is_cfg   <= 1'b0;
                r_grant_id <= w_grant_idx;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    // Pulses are masked during reset so an aborted transaction emits nothing
    assign req_ready    = (w_byte_pick && !reset) ? w_grant : '0;
    assign cfg_div_done = (r_state == ST_STROBE) && wb.wb_ack && r_is_cfg && !reset;

    assign wb.wb_stb      = (r_state == ST_STROBE) || (r_state == ST_RELEASE);
    assign wb.wb_clk      = (r_state == ST_STROBE);
    assign wb.wb_we       = 1'b0;
    assign wb.wb_addr     = r_addr;
    assign wb.wb_data_out = r_data;

    assign grant_id    = r_grant_id;
    assign err_timeout = r_err;

endmodule : uart_tx_arbiter
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench for uart_tx_arbiter. A transaction-level
//               reference model predicts which request is served at each bus
//               cycle start, the bus phases and the status outputs; a UART
//               model answers with configurable ack timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 255;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           cfg_div_valid;
    logic [7:0]     cfg_div;
    logic           cfg_div_done;
    logic [2:0]     grant_id;
    logic           err_timeout;

    uart_tx_arbiter_if bus ();

    uart_tx_arbiter #(
        .N_REQ       (N),
        .ACK_TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .cfg_div_valid (cfg_div_valid),
        .cfg_div       (cfg_div),
        .cfg_div_done  (cfg_div_done),
        .wb            (bus),
        .grant_id      (grant_id),
        .err_timeout   (err_timeout)
    );

    always #5 clk = ~clk;

    // Stimulus state (what requesters/UART drive next cycle)
    logic [N-1:0] rv;
    logic [7:0]   rd [N];
    logic         cv;
    logic [7:0]   cd;
    logic         ack;
    // Inputs and req_ready of the previous cycle (arbitration view)
    logic [N-1:0] p_rv;
    logic [7:0]   p_rd [N];
    logic         p_cv;
    logic [7:0]   p_cd;
    logic [N-1:0] p_rdy;
    // Reference model state: 0 none, 1 strobe, 2 release, 3 gap
    int  last, ph, cnt, idle_wait, ack_delay;
    bit  txn_cfg, exp_err, err_next;
    logic [1:0] txn_addr;
    logic [7:0] txn_data;
    // Knobs
    bit hold_req, rnd_req, rnd_cfg, ack_never, ack_linger, rel_rand;
    int ack_fix;
    // Bookkeeping
    int n_vec = 0, n_err = 0, n_start = 0, n_done = 0;
    logic [9:0] log_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Arbitration rule: next requester after the last grant, cyclically
    function automatic int pick(input logic [N-1:0] m, input int from);
`ifdef UART_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (m[i]) return i;
`else
        for (int k = 1; k <= N; k++) if (m[(from + k) % N]) return (from + k) % N;
`endif
        return 0;
    endfunction

    task automatic apply();
        req_valid = rv;
        for (int i = 0; i < N; i++) req_data[8*i +: 8] = rd[i];
        cfg_div_valid = cv;
        cfg_div       = cd;
        bus.wb_ack    = ack;
    endtask

    task automatic observe();
        int j;
        if (err_next) exp_err = 1'b1;
        err_next = 1'b0;
        n_done += int'(cfg_div_done);
        chk("ready_at_most_one", 32'($countones(req_ready) <= 1), 32'd1);
        if (ph == 0) begin
            if (bus.wb_stb) begin
                n_start++;
                log_q.push_back({bus.wb_addr, bus.wb_data_out});
                chk("start_had_request", 32'((p_rv != '0) || p_cv), 32'd1);
                if (p_cv) begin
                    txn_cfg = 1'b1; txn_addr = 2'd2; txn_data = p_cd;
                    chk("cfg_no_ready", 32'(p_rdy), 32'd0);
                end else begin
                    j = pick(p_rv, last);
                    txn_cfg = 1'b0; txn_addr = 2'd0; txn_data = p_rd[j];
                    chk("ready_grant", 32'(p_rdy), 32'(1) << j);
                    last = j;
                end
                ph = 1; cnt = 0; idle_wait = 0;
                ack_delay = (ack_fix >= 0) ? ack_fix : int'($urandom_range(0, 3));
            end else begin
                chk("ready_without_stb", 32'(p_rdy), 32'd0);
                if ((p_rv != '0) || p_cv) idle_wait++;
                chk("req_to_stb_latency", 32'(idle_wait <= 2), 32'd1);
            end
        end
        case (ph)
            1: begin
                chk("strobe_stb", 32'(bus.wb_stb), 32'd1);
                chk("strobe_clk", 32'(bus.wb_clk), 32'd1);
                chk("strobe_we", 32'(bus.wb_we), 32'd0);
                chk("strobe_addr", 32'(bus.wb_addr), 32'(txn_addr));
                chk("strobe_data", 32'(bus.wb_data_out), 32'(txn_data));
                if (ack) begin
                    chk("cfg_done", 32'(cfg_div_done), 32'(txn_cfg));
                    ph = 2; cnt = 0;
                end else begin
                    chk("done_idle", 32'(cfg_div_done), 32'd0);
                    cnt++;
                    if (cnt == TO) begin err_next = 1'b1; ph = 3; end
                end
            end
            2: begin
                chk("release_stb", 32'(bus.wb_stb), 32'd1);
                chk("release_clk", 32'(bus.wb_clk), 32'd0);
                chk("release_done", 32'(cfg_div_done), 32'd0);
                if (!ack) ph = 3;
                else begin
                    cnt++;
                    if (cnt == TO) begin err_next = 1'b1; ph = 3; end
                end
            end
            3: begin
                chk("gap_stb", 32'(bus.wb_stb), 32'd0);
                chk("gap_clk", 32'(bus.wb_clk), 32'd0);
                chk("gap_done", 32'(cfg_div_done), 32'd0);
                ph = 0; idle_wait = 0;
            end
            default: begin
                chk("idle_clk", 32'(bus.wb_clk), 32'd0);
                chk("idle_done", 32'(cfg_div_done), 32'd0);
            end
        endcase
        chk("grant_id", 32'(grant_id), 32'(last));
        chk("err_timeout", 32'(err_timeout), 32'(exp_err));
        p_rv = rv; p_rd = rd; p_cv = cv; p_cd = cd; p_rdy = req_ready;
        // Requesters: hand-shake and possibly raise new work
        for (int i = 0; i < N; i++) if (req_ready[i] && !hold_req) rv[i] = 1'b0;
        if (cfg_div_done) cv = 1'b0;
        if (rnd_req)
            for (int i = 0; i < N; i++)
                if (!rv[i] && ($urandom_range(0, 3) == 0)) begin
                    rv[i] = 1'b1; rd[i] = 8'($urandom);
                end
        if (rnd_cfg && !cv && ($urandom_range(0, 15) == 0)) begin
            cv = 1'b1; cd = 8'($urandom);
        end
        // UART: ack after ack_delay strobe cycles, then drop (or linger)
        if (ph == 1)      ack = !ack_never && (cnt >= ack_delay);
        else if (ph == 2) ack = ack_linger ? 1'b1 : (rel_rand ? ($urandom_range(0, 1) == 1) : 1'b0);
        else              ack = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
        apply();
        #1;
        observe();
    endtask

    task automatic do_reset();
        reset = 1'b1; rv = '0; cv = 1'b0; cd = '0; ack = 1'b0;
        for (int i = 0; i < N; i++) rd[i] = '0;
        apply();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        last = N - 1; ph = 0; cnt = 0; idle_wait = 0;
        exp_err = 1'b0; err_next = 1'b0;
        p_rv = '0; p_rd = rd; p_cv = 1'b0; p_cd = '0; p_rdy = '0;
        #1;
        chk("rst_stb", 32'(bus.wb_stb), 32'd0);
        chk("rst_clk", 32'(bus.wb_clk), 32'd0);
        chk("rst_we", 32'(bus.wb_we), 32'd0);
        chk("rst_addr", 32'(bus.wb_addr), 32'd0);
        chk("rst_data", 32'(bus.wb_data_out), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_done", 32'(cfg_div_done), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'(N - 1));
        chk("rst_err", 32'(err_timeout), 32'd0);
    endtask

    task automatic wait_starts(input int k, input int budget);
        int base = n_start;
        int t = 0;
        while ((n_start < base + k) && (t < budget)) begin step(); t++; end
        chk("start_budget", 32'(n_start >= base + k), 32'd1);
    endtask

    task automatic drain();
        int t = 0;
        rnd_req = 1'b0; rnd_cfg = 1'b0; hold_req = 1'b0;
        while (!((ph == 0) && !bus.wb_stb && (rv == '0) && !cv && (p_rv == '0) && !p_cv)
               && (t < 800)) begin
            step(); t++;
        end
        chk("drain_budget", 32'(t < 800), 32'd1);
        repeat (3) step();
    endtask

    initial begin
        logic [7:0] exp_seq [5];
        int k, sc, t, base;

        hold_req = 0; rnd_req = 0; rnd_cfg = 0; ack_never = 0;
        ack_linger = 0; rel_rand = 0; ack_fix = -1;
        do_reset();

        // All four requesters held: round-robin byte order from requester 0
`ifdef UART_ARB_FIXED_PRIO_EN
        exp_seq = '{8'h41, 8'h41, 8'h41, 8'h41, 8'h41};
`else
        exp_seq = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h41};
`endif
        hold_req = 1'b1;
        rv = 4'b1111;
        for (int i = 0; i < N; i++) rd[i] = 8'(8'h41 + i);
        log_q.delete();
        wait_starts(5, 200);
        for (int i = 0; i < 5; i++)
            if (i < log_q.size()) chk("rr_sequence", 32'(log_q[i]), 32'({2'd0, exp_seq[i]}));
        rv = '0;
        drain();

        // Divider update beats a concurrent byte request
        log_q.delete();
        n_done = 0;
        rv = 4'b0100; rd[2] = 8'h55;
        cv = 1'b1;    cd    = 8'h27;
        wait_starts(2, 100);
        drain();
        if (log_q.size() >= 2) begin
            chk("cfg_first", 32'(log_q[0]), 32'({2'd2, 8'h27}));
            chk("byte_after_cfg", 32'(log_q[1]), 32'({2'd0, 8'h55}));
        end
        chk("cfg_done_count", 32'(n_done), 32'd1);

        // Single request, UART acks after 3 cycles
        ack_fix = 3;
        rv = 4'b0001; rd[0] = 8'h99;
        base = n_start; k = 0;
        while ((n_start == base) && (k < 20)) begin step(); k++; end
        chk("req_to_stb_cycles", 32'(k), 32'd3);
        sc = 1; t = 0;
        do begin step(); if (bus.wb_stb) sc++; t++; end while (bus.wb_stb && (t < 50));
        chk("stb_high_cycles", 32'(sc), 32'd5);
        drain();

        // Randomized traffic
        ack_fix = -1; rel_rand = 1'b1;
        rnd_req = 1'b1; rnd_cfg = 1'b1;
        repeat (400) step();
        drain();
        rel_rand = 1'b0;

        // No acknowledge at all: timeout, then normal service resumes
        ack_never = 1'b1;
        rv = 4'b0010; rd[1] = 8'hA5;
        wait_starts(1, 20);
        t = 0;
        while ((ph != 0) && (t < 400)) begin step(); t++; end
        step();
        chk("timeout_flag", 32'(err_timeout), 32'd1);
        ack_never = 1'b0;
        rv = 4'b1000; rd[3] = 8'h5A;
        wait_starts(1, 20);
        drain();

        // Reset during the release phase
        do_reset();
        ack_linger = 1'b1;
        rv = 4'b0100; rd[2] = 8'h33;
        t = 0;
        while ((ph != 2) && (t < 50)) begin step(); t++; end
        step();
        chk("in_release", 32'(bus.wb_stb && !bus.wb_clk), 32'd1);
        reset = 1'b1;
        @(posedge clk); #2;
        chk("abort_stb", 32'(bus.wb_stb), 32'd0);
        chk("abort_grant", 32'(grant_id), 32'd3);
        chk("abort_ready", 32'(req_ready), 32'd0);
        chk("abort_done", 32'(cfg_div_done), 32'd0);
        ack_linger = 1'b0;
        do_reset();
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_uart_tx_arbiter
`default_nettype wire
